// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the OpenMIPS pipeline control slice.
// Stage indices, controller states and stall levels.
package pipe_ctrl_pkg;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/pipe_stall_encoder.sv
// Request vector to thermometer stall vector.
// A stall at stage k freezes every earlier stage as well.
module pipe_stall_encoder
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 6
) (
  input  logic [NUM_STAGES-1:0] req,
  output logic [NUM_STAGES-1:0] therm
);

  logic acc;

  always_comb begin
    acc   = NO_STOP;
    therm = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      acc      = acc | req[i];
      therm[i] = acc;
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control: stall arbitration, exception flush,
// stall watchdog and stall-cycle performance counter.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int              NUM_STAGES = 6,
  parameter int              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = EXC_VECTOR_DEF[ADDR_W-1:0],
  parameter int              FLUSH_LEN  = 1,
  parameter int              MAX_STALL  = 64,
  parameter int              CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stallreq,
  input  logic                  exc_req,
  input  logic                  exc_eret,
  input  logic [ADDR_W-1:0]     epc,
  input  logic                  wd_clear,
  output logic [NUM_STAGES-1:0] stall,
  output logic                  flush,
  output logic [ADDR_W-1:0]     new_pc,
  output logic                  stall_timeout,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int FC_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam int WD_W = $clog2(MAX_STALL);
  localparam logic [FC_W-1:0] FC_INIT = FC_W'(FLUSH_LEN - 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(MAX_STALL - 1);

  ctrl_state_t       state_q, state_d;
  logic              flush_q, flush_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              to_q, to_d;
  logic [CNT_W-1:0]  perf_q, perf_d;
  logic [NUM_STAGES-1:0] therm;
  logic              stalled;
  logic              wd_set;

  pipe_stall_encoder #(
    .NUM_STAGES(NUM_STAGES)
  ) u_enc (
    .req  (stallreq),
    .therm(therm)
  );

  // Exceptions and an in-flight flush outrank every stall.
  always_comb begin
    stall = therm;
    if (rst || state_q == FLUSH || exc_req) begin
      stall = '0;
    end
  end

  assign stalled = |stall;

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    pc_d    = pc_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      RUN: begin
        if (exc_req) begin
          state_d = FLUSH;
          flush_d = 1'b1;
          pc_d    = exc_eret ? epc : EXC_VECTOR;
          fcnt_d  = FC_INIT;
        end
      end
      FLUSH: begin
        if (fcnt_q == '0) begin
          state_d = RUN;
          flush_d = 1'b0;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        flush_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    wd_set = stalled && (wd_q == WD_MAX);
    wd_d   = wd_q;
    if (!stalled) begin
      wd_d = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + 1'b1;
    end
    to_d = to_q;
    if (wd_set) begin
      to_d = 1'b1;
    end else if (wd_clear) begin
      to_d = 1'b0;
    end
    perf_d = perf_q;
    if (stalled && perf_q != '1) begin
      perf_d = perf_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      flush_q <= 1'b0;
      pc_q    <= '0;
      fcnt_q  <= '0;
      wd_q    <= '0;
      to_q    <= 1'b0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      pc_q    <= pc_d;
      fcnt_q  <= fcnt_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
      perf_q  <= perf_d;
    end
  end

  assign flush         = flush_q;
  assign new_pc        = pc_q;
  assign stall_timeout = to_q;
  assign stall_cycles  = perf_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit.
// Three instances cover the different flush lengths.
module tb_pipe_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stallreq;
  logic        exc_req;
  logic        exc_eret;
  logic [31:0] epc;
  logic        wd_clear;

  logic [5:0]  stall_a, stall_b, stall_c;
  logic        flush_a, flush_b, flush_c;
  logic [31:0] pc_a, pc_b, pc_c;
  logic        to_a, to_b, to_c;
  logic [2:0]  cyc_a;
  logic [15:0] cyc_b, cyc_c;

  int n_chk = 0;
  int n_ok  = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(
    .FLUSH_LEN(1), .MAX_STALL(4), .CNT_W(3)
  ) u_a (
    .clk(clk), .rst(rst), .stallreq(stallreq),
    .exc_req(exc_req), .exc_eret(exc_eret), .epc(epc),
    .wd_clear(wd_clear), .stall(stall_a), .flush(flush_a),
    .new_pc(pc_a), .stall_timeout(to_a), .stall_cycles(cyc_a)
  );

  pipe_ctrl_unit #(
    .FLUSH_LEN(3)
  ) u_b (
    .clk(clk), .rst(rst), .stallreq(stallreq),
    .exc_req(exc_req), .exc_eret(exc_eret), .epc(epc),
    .wd_clear(wd_clear), .stall(stall_b), .flush(flush_b),
    .new_pc(pc_b), .stall_timeout(to_b), .stall_cycles(cyc_b)
  );

  pipe_ctrl_unit #(
    .FLUSH_LEN(4)
  ) u_c (
    .clk(clk), .rst(rst), .stallreq(stallreq),
    .exc_req(exc_req), .exc_eret(exc_eret), .epc(epc),
    .wd_clear(wd_clear), .stall(stall_c), .flush(flush_c),
    .new_pc(pc_c), .stall_timeout(to_c), .stall_cycles(cyc_c)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_ok++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    stallreq = 6'h3f;
    exc_req = 1'b0;
    exc_eret = 1'b0;
    epc = 32'h0;
    wd_clear = 1'b0;
    tick();
    tick();
    chk("rst_stall", 32'(stall_a), 32'h0);
    chk("rst_flush", 32'(flush_a), 32'h0);
    chk("rst_pc", pc_a, 32'h0);
    chk("rst_to", 32'(to_a), 32'h0);
    chk("rst_cyc", 32'(cyc_a), 32'h0);
    rst = 1'b0;
    stallreq = 6'h0;
    tick();

    stallreq = 6'b001000;
    #1 chk("therm_ex", 32'(stall_a), 32'h0f);
    tick();
    stallreq = 6'b000100;
    #1 chk("therm_id", 32'(stall_a), 32'h07);
    tick();
    stallreq = 6'b000000;
    #1 chk("therm_none", 32'(stall_a), 32'h00);
    chk("cyc_two", 32'(cyc_a), 32'h2);
    tick();

    stallreq = 6'b001100;
    exc_req = 1'b1;
    exc_eret = 1'b0;
    #1 chk("exc_prio", 32'(stall_a), 32'h0);
    chk("exc_noflush", 32'(flush_a), 32'h0);
    tick();
    exc_req = 1'b0;
    stallreq = 6'b0;
    chk("exc_flush", 32'(flush_a), 32'h1);
    chk("exc_pc", pc_a, 32'h20);
    tick();
    chk("exc_flush_end", 32'(flush_a), 32'h0);
    chk("exc_cyc", 32'(cyc_a), 32'h2);
    do_reset();

    exc_req = 1'b1;
    exc_eret = 1'b1;
    epc = 32'h0000_1234;
    tick();
    exc_req = 1'b0;
    stallreq = 6'b001000;
    #1 chk("eret_stall0", 32'(stall_b), 32'h0);
    chk("eret_f1", 32'(flush_b), 32'h1);
    chk("eret_pc1", pc_b, 32'h1234);
    tick();
    exc_req = 1'b1;
    exc_eret = 1'b0;
    chk("eret_f2", 32'(flush_b), 32'h1);
    tick();
    exc_req = 1'b0;
    stallreq = 6'b0;
    chk("eret_f3", 32'(flush_b), 32'h1);
    chk("eret_pc3", pc_b, 32'h1234);
    tick();
    chk("eret_f4", 32'(flush_b), 32'h0);
    chk("eret_cyc", 32'(cyc_b), 32'h0);
    do_reset();

    stallreq = 6'b000100;
    repeat (3) tick();
    stallreq = 6'b0;
    tick();
    chk("wd_gap", 32'(to_a), 32'h0);
    stallreq = 6'b000100;
    repeat (3) tick();
    chk("wd_three", 32'(to_a), 32'h0);
    tick();
    chk("wd_four", 32'(to_a), 32'h1);
    wd_clear = 1'b1;
    tick();
    chk("wd_setwins", 32'(to_a), 32'h1);
    stallreq = 6'b0;
    tick();
    chk("wd_clear", 32'(to_a), 32'h0);
    wd_clear = 1'b0;
    do_reset();

    stallreq = 6'b000100;
    repeat (6) tick();
    chk("sat_six", 32'(cyc_a), 32'h6);
    repeat (4) tick();
    chk("sat_hold", 32'(cyc_a), 32'h7);
    chk("cnt_wide", 32'(cyc_b), 32'd10);
    stallreq = 6'b0;

    exc_req = 1'b1;
    exc_eret = 1'b1;
    epc = 32'h0000_1234;
    tick();
    exc_req = 1'b0;
    tick();
    chk("mid_flush", 32'(flush_c), 32'h1);
    chk("mid_pc", pc_c, 32'h1234);
    rst = 1'b1;
    tick();
    chk("abort_flush", 32'(flush_c), 32'h0);
    chk("abort_pc", pc_c, 32'h0);
    chk("abort_cyc", 32'(cyc_c), 32'h0);
    chk("abort_to", 32'(to_a), 32'h0);
    rst = 1'b0;
    tick();
    chk("abort_run", 32'(flush_c), 32'h0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
